pulse_bram_reader: RTL
======================

# pulse_bram_reader

Drain stage downstream of the pulse generator. After a generation run, it sweeps the pulse BRAM from word 0 to DEPTH-1 and streams each word out on a valid/ready interface. Each word is optionally cleared after it is read, and the block accumulates a saturating total. It owns the pulse BRAM port only while busy; top-level arbitration guarantees the generator is idle (cps == 0) during a sweep.

## Interface
- DEPTH, 1024: number of 32-bit words swept; word i sits at byte address i*ADDR_STEP.
- ADDR_STEP, 4: byte-address increment per word.
- DATA_W, 32: BRAM and stream data width.

Clocking and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle sweep request; sampled only in IDLE.
- clear_on_read  in  1  latched at start; 1 = write 0 back after each word is delivered.
- abort  in  1  synchronous sweep cancel.
- busy  out  1  high from the cycle after accepted start until DONE exits.
- done  out  1  one-cycle pulse at sweep completion; not asserted on abort.
- total  out  32  saturating sum of swept words; cleared at start, held after done.
- bram_addr  out  32  byte address to the BRAM.
- bram_data_in  out  32  write data; always 0.
- bram_we  out  1  write enable.
- bram_ena  out  1  port enable.
- bram_data_out  in  32  BRAM read data, registered, one-cycle latency.
- m_data  out  DATA_W  word value.
- m_index  out  32  word index 0..DEPTH-1.
- m_valid  out  1  beat valid.
- m_ready  in  1  consumer ready.
- m_last  out  1  high with the beat for index DEPTH-1.

## Operation
- Reset values: every output is 0, state is IDLE, index is 0.
- When not busy, bram_ena and bram_we are 0.

FSM states: IDLE, RD, WAIT, CAP, OUT, CLR, DONE.
- IDLE: on start, latch clear_on_read, set idx=0, total=0, busy=1, then go to RD. start in any other state is ignored.
- RD: bram_ena=1, bram_we=0, bram_addr=idx*ADDR_STEP. Go to WAIT.
- WAIT: bram_ena=0. Go to CAP.
- CAP: m_data←bram_data_out, m_index←idx, m_last←(idx==DEPTH-1), m_valid←1, total←sat(total+bram_data_out). Go to OUT.
- OUT: hold m_data, m_index and m_last stable while m_valid && !m_ready. On handshake, m_valid←0, then:
  - if clear is set, go to CLR;
  - else if idx==DEPTH-1, go to DONE;
  - else idx←idx+1 and go to RD.
- CLR: bram_ena=1, bram_we=1, bram_data_in=0, same address. Then go to DONE if idx==DEPTH-1; else idx←idx+1 and go to RD.
- DONE: done=1 for one cycle, busy←0. Go to IDLE.

Arithmetic:
- total saturates at 0xFFFFFFFF and never wraps.
- Address is idx*ADDR_STEP truncated to 32 bits.
- The index counter does not wrap past DEPTH-1.

abort:
- Checked in every non-IDLE state, with priority over all other transitions.
- Next cycle: state IDLE, m_valid=0, bram_ena=0, bram_we=0, busy=0, no done.
- total keeps its partial value.
- A CLR write in progress at the abort edge is not issued.

rst_n asserted mid-sweep: all outputs go to reset values immediately, asynchronously. The next start sweeps from index 0.

## Timing
- start sampled at edge k → RD (ena=1, addr 0) in the cycle after k → m_valid rises at edge k+3.
- Per-word cost with m_ready held high:
  - 4 cycles (RD, WAIT, CAP, OUT);
  - 5 cycles with clear (adds CLR).
- Each extra cycle of m_ready low adds one cycle. No BRAM access occurs while stalled.
- done asserts in the cycle after the final OUT handshake, or after the final CLR write.
- Full sweep, no stall: 4*DEPTH+2 cycles from start to done (5*DEPTH+2 with clear).
- Read timing: data is captured two edges after the RD issue edge. This matches the read→wait→use timing of the generator's read-modify-write.

## Structure
- Shared package pulse_pkg holds:
  - ADDR_STEP;
  - the word-width constant;
  - the reader state enum;
  - the saturating-add function (also used by future histogram stages).
- One sub-module is natural: pulse_sat_acc, a 32-bit saturating accumulator with clear and enable.
- The FSM, index counter and stream register stay in the top module.

## Test plan
- Sweep without clear: DEPTH=4, words {5,0,7,1}, clear=0, m_ready=1.
  - Required: 4 beats, index 0..3, data 5,0,7,1; m_last only on beat 3.
  - Required: done exactly 1 cycle after the last handshake; total=13; memory unchanged.
- Sweep with clear: same preload, clear=1.
  - Required: identical stream, after which all 4 words read 0.
  - Required: a second sweep gives total=0, and 22 cycles elapse from start to done.
- Backpressure: m_ready low for 10 cycles during beat 1.
  - Required: m_data=0, m_index=1 and m_valid held stable.
  - Required: bram_ena stays 0 throughout the stall.
- Saturation: words {0xFFFFFFF0, 0x20, 0, 0}.
  - Required: total=0xFFFFFFFF.
- Reset mid-sweep: rst_n low during beat 2.
  - Required: all outputs 0 at once, with no done.
  - Required: a following start restarts at index 0.
- Abort and start while busy: abort during CLR of index 1; separately, start pulsed while busy.
  - Required (abort): word 1 is not cleared, busy drops next cycle, no done.
  - Required (start while busy): the sweep continues unaffected.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse datapath: word width, BRAM address step,
// the reader FSM state encoding and a saturating adder.
package pulse_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CAP,
    S_OUT,
    S_CLR,
    S_DONE
  } reader_state_e;

  // Unsigned add that clamps to all-ones instead of wrapping.
  function automatic logic [WORD_W-1:0] satAdd(input logic [WORD_W-1:0] a,
                                               input logic [WORD_W-1:0] b);
    logic [WORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WORD_W] ? {WORD_W{1'b1}} : sum[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/pulse_bram_reader_if.sv
// Bundles the pulse BRAM port and the outgoing valid/ready word stream.
// The master side is the reader; the slave side is the BRAM plus consumer.
interface pulse_bram_reader_if #(
  parameter int DATA_W = pulse_pkg::WORD_W
) ();
  import pulse_pkg::*;

  logic [31:0]       bram_addr;
  logic [WORD_W-1:0] bram_data_in;
  logic              bram_we;
  logic              bram_ena;
  logic [WORD_W-1:0] bram_data_out;

  logic [DATA_W-1:0] m_data;
  logic [31:0]       m_index;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output bram_addr, bram_data_in, bram_we, bram_ena,
    output m_data, m_index, m_valid, m_last,
    input  bram_data_out, m_ready
  );

  modport slave (
    input  bram_addr, bram_data_in, bram_we, bram_ena,
    input  m_data, m_index, m_valid, m_last,
    output bram_data_out, m_ready
  );

endinterface

// File: rtl/pulse_sat_acc.sv
// 32-bit accumulator that clamps at all-ones; clear wins over enable.
module pulse_sat_acc
  import pulse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] acc_o
);

  logic [WORD_W-1:0] acc_q;

  // Running total: cleared at sweep start, bumped once per captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= satAdd(acc_q, data_i);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pulse_bram_reader.sv
// Drains the pulse BRAM after a generation run: reads word 0..DEPTH-1,
// streams each on valid/ready, optionally zeroes it, and keeps a
// saturating total of everything read.
module pulse_bram_reader
  import pulse_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       clear_on_read_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [WORD_W-1:0]          total_o,
  pulse_bram_reader_if.master        bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  reader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              clearOnRead_q, clearOnRead_d;
  logic              busy_q, busy_d;
  logic              mValid_q, mValid_d;
  logic [WORD_W-1:0] mData_q, mData_d;
  logic [31:0]       mIndex_q, mIndex_d;
  logic              mLast_q, mLast_d;

  logic              accClear;
  logic              accEn;
  logic              bramEna;
  logic              bramWe;
  logic              idxLast;

  assign idxLast = (idx_q == IDX_W'(DEPTH - 1));

  // State, index and stream registers; everything returns to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      clearOnRead_q <= 1'b0;
      busy_q        <= 1'b0;
      mValid_q      <= 1'b0;
      mData_q       <= '0;
      mIndex_q      <= '0;
      mLast_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      clearOnRead_q <= clearOnRead_d;
      busy_q        <= busy_d;
      mValid_q      <= mValid_d;
      mData_q       <= mData_d;
      mIndex_q      <= mIndex_d;
      mLast_q       <= mLast_d;
    end
  end

  // Sweep sequencing; abort overrides every transition and also suppresses
  // the BRAM write of a CLR cycle in the same cycle it is raised.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    clearOnRead_d = clearOnRead_q;
    busy_d        = busy_q;
    mValid_d      = mValid_q;
    mData_d       = mData_q;
    mIndex_d      = mIndex_q;
    mLast_d       = mLast_q;
    accClear      = 1'b0;
    accEn         = 1'b0;
    bramEna       = 1'b0;
    bramWe        = 1'b0;

    if (state_q != S_IDLE && abort_i) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      mValid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            clearOnRead_d = clear_on_read_i;
            idx_d         = '0;
            accClear      = 1'b1;
            busy_d        = 1'b1;
            state_d       = S_RD;
          end
        end
        S_RD: begin
          bramEna = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          state_d = S_CAP;
        end
        S_CAP: begin
          mData_d  = bus.bram_data_out;
          mIndex_d = 32'(idx_q);
          mLast_d  = idxLast;
          mValid_d = 1'b1;
          accEn    = 1'b1;
          state_d  = S_OUT;
        end
        S_OUT: begin
          if (bus.m_ready) begin
            mValid_d = 1'b0;
            if (clearOnRead_q) begin
              state_d = S_CLR;
            end else if (idxLast) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_RD;
            end
          end
        end
        S_CLR: begin
          bramEna = 1'b1;
          bramWe  = 1'b1;
          if (idxLast) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD;
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  pulse_sat_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accClear),
    .en_i    (accEn),
    .data_i  (bus.bram_data_out),
    .acc_o   (total_o)
  );

  assign busy_o = busy_q;
  assign done_o = (state_q == S_DONE);

  assign bus.bram_addr    = 32'(idx_q) * ADDR_STEP;
  assign bus.bram_data_in = '0;
  assign bus.bram_ena     = bramEna;
  assign bus.bram_we      = bramWe;
  assign bus.m_data       = mData_q;
  assign bus.m_index      = mIndex_q;
  assign bus.m_valid      = mValid_q;
  assign bus.m_last       = mLast_q;

endmodule
